// File: rtl/nib_track_writer_pkg.sv
// Shared constants and types for the NIB track write-back block.
package nib_track_writer_pkg;

  // 512-byte SD sectors per NIB track unless overridden.
  localparam int SECTORS_DEFAULT = 13;

  // Bytes per SD sector and the matching host byte-index width.
  localparam int SECTOR_BYTES = 512;
  localparam int SD_ADDR_W    = $clog2(SECTOR_BYTES);

  // Sector counter width; together with the byte index it spans the 8 KiB track RAM.
  localparam int SEC_W = 4;

  // Write-back sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER,
    FIN
  } wr_state_t;

endpackage

// File: rtl/nib_track_writer_if.sv
// SD host block-write bus: the writer (master) requests sectors, the host (slave)
// acknowledges and walks the byte index while pulling data.
interface nib_track_writer_if;
  import nib_track_writer_pkg::*;

  logic [31:0]          sd_lba;
  logic                 sd_wr;
  logic                 sd_ack;
  logic [SD_ADDR_W-1:0] sd_buff_addr;
  logic [7:0]           sd_buff_din;

  modport master (
    output sd_lba,
    output sd_wr,
    output sd_buff_din,
    input  sd_ack,
    input  sd_buff_addr
  );

  modport slave (
    input  sd_lba,
    input  sd_wr,
    input  sd_buff_din,
    output sd_ack,
    output sd_buff_addr
  );

endinterface

// File: rtl/nib_ack_edge.sv
// Registers the host acknowledge and reports its rising and falling edges
// as single-cycle pulses.
module nib_ack_edge (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ack,
  output logic rise,
  output logic fall
);

  logic ack_reg;

  // Previous-cycle copy of the acknowledge for edge detection.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) ack_reg <= 1'b0;
    else          ack_reg <= ack;
  end

  assign rise = ack & ~ack_reg;
  assign fall = ~ack & ack_reg;

endmodule

// File: rtl/nib_track_writer.sv
// Writes a dirty NIB track from track RAM back to the SD image, one 512-byte
// sector per host acknowledge, when flushed or when the head leaves the track.
// Optional feature: define NIB_WRITE_PROTECT_EN to add the wp input.
module nib_track_writer
  import nib_track_writer_pkg::*;
#(
  parameter int SECTORS = SECTORS_DEFAULT,
  parameter int TRK_W   = 6
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
`ifdef NIB_WRITE_PROTECT_EN
  input  logic                 wp,
`endif
  input  logic [TRK_W-1:0]     track,
  input  logic                 trk_we,
  input  logic                 flush,
  input  logic                 img_mounted,
  input  logic [63:0]          img_size,
  nib_track_writer_if.master   sd,
  output logic [12:0]          tram_addr,
  input  logic [7:0]           tram_do,
  output logic                 busy,
  output logic                 dirty
);

  wr_state_t        state_reg, state_next;
  logic             dirty_reg, dirty_next;
  logic             busy_reg;
  logic             sd_wr_reg;
  logic [31:0]      sd_lba_reg;
  logic [SEC_W-1:0] sec_reg;
  logic [TRK_W-1:0] wr_track_reg;
  logic             start_go;
  logic             ack_rise, ack_fall;
  logic             wp_eff;
  logic             img_present;

`ifdef NIB_WRITE_PROTECT_EN
  assign wp_eff = wp;
`else
  assign wp_eff = 1'b0;
`endif

  assign img_present = |img_size;

  nib_ack_edge u_ack_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ack     (sd.sd_ack),
    .rise    (ack_rise),
    .fall    (ack_fall)
  );

  // Sequencer state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; a new image always wins and drops back to IDLE.
  always_comb begin
    state_next = state_reg;
    start_go   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dirty_reg && img_present && !wp_eff &&
            (flush || (track != wr_track_reg))) begin
          state_next = START;
          start_go   = 1'b1;
        end
      end
      START: if (ack_rise) state_next = XFER;
      XFER:  if (ack_fall && !sd_wr_reg) state_next = FIN;
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (img_mounted) begin
      state_next = IDLE;
      start_go   = 1'b0;
    end
  end

  // Dirty flag: a write strobe beats the clear at write-back start; no image
  // or a fresh mount always forces it clean.
  always_comb begin
    dirty_next = dirty_reg;
    if (start_go) dirty_next = 1'b0;
    if (trk_we && img_present && !wp_eff) dirty_next = 1'b1;
    if (img_mounted || !img_present) dirty_next = 1'b0;
  end

  // Transfer datapath: LBA, sector counter, write request, busy and track latch.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      dirty_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      sd_wr_reg    <= 1'b0;
      sd_lba_reg   <= '0;
      sec_reg      <= '0;
      wr_track_reg <= '0;
    end else begin
      dirty_reg <= dirty_next;
      if (!dirty_reg && dirty_next) wr_track_reg <= track;

      if (img_mounted) begin
        sd_wr_reg <= 1'b0;
        busy_reg  <= 1'b0;
      end else if (start_go) begin
        sd_lba_reg <= 32'(SECTORS) * 32'(wr_track_reg);
        sec_reg    <= '0;
        sd_wr_reg  <= 1'b1;
        busy_reg   <= 1'b1;
      end else begin
        // The LBA runs one ahead of the sector being moved; the last
        // sector's acknowledge withdraws the write request.
        if (ack_rise && ((state_reg == START) || (state_reg == XFER))) begin
          sd_lba_reg <= sd_lba_reg + 32'd1;
          if (sec_reg == SEC_W'(SECTORS - 1)) sd_wr_reg <= 1'b0;
        end
        if (ack_fall && (state_reg == XFER)) begin
          sec_reg <= sec_reg + 1'b1;
          if (!sd_wr_reg) busy_reg <= 1'b0;
        end
      end
    end
  end

  assign sd.sd_lba      = sd_lba_reg;
  assign sd.sd_wr       = sd_wr_reg;
  assign sd.sd_buff_din = tram_do;
  assign tram_addr      = {sec_reg, sd.sd_buff_addr};
  assign busy           = busy_reg;
  assign dirty          = dirty_reg;

endmodule

// File: tb/tb_nib_track_writer.sv
// Self-checking bench for nib_track_writer: a host model serves sector
// acknowledges and the expected LBA sequence comes from track*SECTORS+index.
module tb_nib_track_writer;
  import nib_track_writer_pkg::*;

  localparam int SECTORS = 13;
  localparam int TRK_W   = 6;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic [TRK_W-1:0] track;
  logic             trk_we;
  logic             flush;
  logic             img_mounted;
  logic [63:0]      img_size;
  logic [12:0]      tram_addr;
  logic [7:0]       tram_do;
  logic             busy;
  logic             dirty;
`ifdef NIB_WRITE_PROTECT_EN
  logic             wp = 1'b0;
`endif

  nib_track_writer_if sd ();

  nib_track_writer #(.SECTORS(SECTORS), .TRK_W(TRK_W)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
`ifdef NIB_WRITE_PROTECT_EN
    .wp          (wp),
`endif
    .track       (track),
    .trk_we      (trk_we),
    .flush       (flush),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .sd          (sd.master),
    .tram_addr   (tram_addr),
    .tram_do     (tram_do),
    .busy        (busy),
    .dirty       (dirty)
  );

  always #5 clk_sys = ~clk_sys;

  // Track RAM stand-in with one-cycle read latency.
  logic [7:0] tram_mem [0:8191];
  always @(posedge clk_sys) tram_do <= tram_mem[tram_addr];

  int checks   = 0;
  int failures = 0;

  // Reference model: expected LBA of each sector of a write-back.
  int exp_lba_q[$];
  // Observations recorded by the host model, one entry per sector served.
  int obs_lba[$];
  bit obs_wr[$];
  bit obs_busy[$];

  function automatic int ref_lba(input int trk, input int idx);
    return trk * SECTORS + idx;
  endfunction

  task automatic plan_writeback(input int trk);
    for (int i = 0; i < SECTORS; i++) exp_lba_q.push_back(ref_lba(trk, i));
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic wait_wr(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sd.sd_wr === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Host model: serve n sectors, recording LBA at request, sd_wr late in the
  // ack pulse, and busy right after the ack falls.
  task automatic serve(input int n, output bit timeout);
    bit ok;
    timeout = 1'b0;
    obs_lba.delete();
    obs_wr.delete();
    obs_busy.delete();
    for (int i = 0; i < n; i++) begin
      wait_wr(100, ok);
      if (!ok) begin
        timeout = 1'b1;
        return;
      end
      obs_lba.push_back(int'(sd.sd_lba));
      sd.sd_ack = 1'b1;
      repeat ($urandom_range(2, 5)) begin
        sd.sd_buff_addr = 9'($urandom);
        tick();
      end
      obs_wr.push_back(sd.sd_wr);
      sd.sd_ack = 1'b0;
      tick();
      obs_busy.push_back(busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (sd.sd_wr !== 1'b0) begin failures++; $display("FAIL reset_sd_wr: got %b expected 0", sd.sd_wr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL reset_dirty: got %b expected 0", dirty); end
    checks++; if (sd.sd_lba !== 32'd0) begin failures++; $display("FAIL reset_lba: got %0d expected 0", sd.sd_lba); end
    reset_n = 1'b1;
    img_size = {32'($urandom), 32'($urandom)} | 64'd1;
    img_mounted = 1'b1; tick(); img_mounted = 1'b0; tick();
    $display("test_reset done");
  endtask

  task automatic test_flush_writeback();
    bit to;
    track = 6'd5; tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL flush_dirty_set: got %b expected 1", dirty); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_no_autostart: got %b expected 0", busy); end
    flush = 1'b1; tick(); flush = 1'b0;
    plan_writeback(5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy: got %b expected 1", busy); end
    checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL flush_dirty_clr: got %b expected 0", dirty); end
    serve(SECTORS, to);
    checks++; if (to) begin failures++; $display("FAIL flush_timeout: got %0d sectors expected %0d", obs_lba.size(), SECTORS); end
    for (int i = 0; i < obs_lba.size(); i++) begin
      int e;
      e = exp_lba_q.pop_front();
      checks++; if (obs_lba[i] != e) begin failures++; $display("FAIL flush_lba[%0d]: got %0d expected %0d", i, obs_lba[i], e); end
      checks++; if (obs_wr[i] != (i != SECTORS - 1)) begin failures++; $display("FAIL flush_wr[%0d]: got %b expected %b", i, obs_wr[i], i != SECTORS - 1); end
      checks++; if (obs_busy[i] != (i != SECTORS - 1)) begin failures++; $display("FAIL flush_busy[%0d]: got %b expected %b", i, obs_busy[i], i != SECTORS - 1); end
    end
    exp_lba_q.delete();
    repeat (4) tick();
    checks++; if (sd.sd_wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_end: got wr=%b busy=%b expected 0 0", sd.sd_wr, busy); end
    $display("test_flush_writeback done");
  endtask

  task automatic test_track_change();
    bit to;
    track = 6'd3; tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    track = 6'd4; tick();
    plan_writeback(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL trkchg_start: got %b expected 1", busy); end
    serve(SECTORS, to);
    checks++; if (to) begin failures++; $display("FAIL trkchg_timeout: got %0d sectors expected %0d", obs_lba.size(), SECTORS); end
    for (int i = 0; i < obs_lba.size(); i++) begin
      int e;
      e = exp_lba_q.pop_front();
      checks++; if (obs_lba[i] != e) begin failures++; $display("FAIL trkchg_lba[%0d]: got %0d expected %0d", i, obs_lba[i], e); end
    end
    exp_lba_q.delete();
    tick();
    checks++; if (busy !== 1'b0 || dirty !== 1'b0) begin failures++; $display("FAIL trkchg_end: got busy=%b dirty=%b expected 0 0", busy, dirty); end
    $display("test_track_change done");
  endtask

  task automatic test_img_mount_abort();
    bit to, ok, bad;
    logic [31:0] lba_hold;
    track = 6'($urandom_range(0, 63)); tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    serve(6, to);
    checks++; if (to) begin failures++; $display("FAIL mount_pre_timeout: got %0d sectors expected 6", obs_lba.size()); end
    wait_wr(100, ok);
    sd.sd_ack = 1'b1; tick(); tick();
    img_mounted = 1'b1; tick(); img_mounted = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mount_busy: got %b expected 0", busy); end
    checks++; if (sd.sd_wr !== 1'b0) begin failures++; $display("FAIL mount_sd_wr: got %b expected 0", sd.sd_wr); end
    checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL mount_dirty: got %b expected 0", dirty); end
    lba_hold = sd.sd_lba;
    tick(); sd.sd_ack = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (sd.sd_wr !== 1'b0 || busy !== 1'b0 || sd.sd_lba !== lba_hold) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL mount_quiet: got activity=1 expected 0"); end
    $display("test_img_mount_abort done");
  endtask

  task automatic test_rewrite_during_xfer();
    bit to, ok;
    int t;
    t = $urandom_range(0, 63);
    track = 6'(t); tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    plan_writeback(t);
    serve(4, to);
    for (int i = 0; i < obs_lba.size(); i++) begin
      int e;
      e = exp_lba_q.pop_front();
      checks++; if (obs_lba[i] != e) begin failures++; $display("FAIL rewr_lba_a[%0d]: got %0d expected %0d", i, obs_lba[i], e); end
    end
    wait_wr(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rewr_sec4_wait: got wr=0 expected 1"); end
    void'(exp_lba_q.pop_front());
    sd.sd_ack = 1'b1; tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    tick(); sd.sd_ack = 1'b0; tick();
    serve(SECTORS - 5, to);
    for (int i = 0; i < obs_lba.size(); i++) begin
      int e;
      e = exp_lba_q.pop_front();
      checks++; if (obs_lba[i] != e) begin failures++; $display("FAIL rewr_lba_b[%0d]: got %0d expected %0d", i, obs_lba[i], e); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rewr_first_done: got %b expected 0", busy); end
    tick(); tick();
    checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL rewr_dirty: got %b expected 1", dirty); end
    flush = 1'b1; tick(); flush = 1'b0;
    exp_lba_q.delete();
    plan_writeback(t);
    serve(SECTORS, to);
    checks++; if (to) begin failures++; $display("FAIL rewr_second_timeout: got %0d sectors expected %0d", obs_lba.size(), SECTORS); end
    for (int i = 0; i < obs_lba.size(); i++) begin
      int e;
      e = exp_lba_q.pop_front();
      checks++; if (obs_lba[i] != e) begin failures++; $display("FAIL rewr_lba_c[%0d]: got %0d expected %0d", i, obs_lba[i], e); end
    end
    exp_lba_q.delete();
    tick();
    checks++; if (dirty !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rewr_end: got dirty=%b busy=%b expected 0 0", dirty, busy); end
    $display("test_rewrite_during_xfer done");
  endtask

  task automatic test_buffer_read();
    bit to, ok;
    int addr_bad, data_bad;
    track = 6'($urandom_range(0, 63)); tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    serve(2, to);
    wait_wr(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL buf_wait: got wr=0 expected 1"); end
    sd.sd_ack = 1'b1;
    addr_bad = 0;
    data_bad = 0;
    for (int a = 0; a < SECTOR_BYTES; a++) begin
      logic [12:0] ea;
      sd.sd_buff_addr = 9'(a);
      tick();
      ea = 13'(2 * SECTOR_BYTES + a);
      checks++; if (tram_addr !== ea) begin failures++; addr_bad++; if (addr_bad < 4) $display("FAIL buf_addr[%0d]: got %0d expected %0d", a, tram_addr, ea); end
      checks++; if (sd.sd_buff_din !== tram_mem[ea]) begin failures++; data_bad++; if (data_bad < 4) $display("FAIL buf_data[%0d]: got %0d expected %0d", a, sd.sd_buff_din, tram_mem[ea]); end
    end
    sd.sd_ack = 1'b0; tick();
    serve(SECTORS - 3, to);
    checks++; if (to || busy !== 1'b0) begin failures++; $display("FAIL buf_finish: got busy=%b timeout=%b expected 0 0", busy, to); end
    $display("test_buffer_read done");
  endtask

  task automatic test_no_image();
    bit bad;
    img_size = 64'd0;
    img_mounted = 1'b1; tick(); img_mounted = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      trk_we = 1'($urandom);
      flush = 1'($urandom);
      track = 6'($urandom);
      tick();
      if (dirty !== 1'b0 || sd.sd_wr !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    trk_we = 1'b0; flush = 1'b0;
    checks++; if (bad) begin failures++; $display("FAIL noimg_quiet: got activity=1 expected 0"); end
    img_size = {32'($urandom), 32'($urandom)} | 64'd1;
    img_mounted = 1'b1; tick(); img_mounted = 1'b0; tick();
    $display("test_no_image done");
  endtask

  task automatic test_flush_not_dirty();
    bit bad;
    bad = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (5) begin
      tick();
      if (busy !== 1'b0 || sd.sd_wr !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL clean_flush: got activity=1 expected 0"); end
    $display("test_flush_not_dirty done");
  endtask

  task automatic test_we_at_start();
    bit to;
    int t;
    t = $urandom_range(0, 63);
    track = 6'(t); tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    flush = 1'b1; trk_we = 1'b1; tick(); flush = 1'b0; trk_we = 1'b0;
    plan_writeback(t);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL westart_busy: got %b expected 1", busy); end
    checks++; if (dirty !== 1'b1) begin failures++; $display("FAIL westart_dirty: got %b expected 1", dirty); end
    serve(SECTORS, to);
    for (int i = 0; i < obs_lba.size(); i++) begin
      int e;
      e = exp_lba_q.pop_front();
      checks++; if (obs_lba[i] != e) begin failures++; $display("FAIL westart_lba[%0d]: got %0d expected %0d", i, obs_lba[i], e); end
    end
    exp_lba_q.delete();
    img_mounted = 1'b1; tick(); img_mounted = 1'b0;
    checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL westart_mount_clr: got %b expected 0", dirty); end
    $display("test_we_at_start done");
  endtask

  task automatic test_reset_mid();
    bit to, bad;
    track = 6'($urandom_range(1, 63)); tick();
    trk_we = 1'b1; tick(); trk_we = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    serve(9, to);
    checks++; if (to) begin failures++; $display("FAIL rstmid_pre_timeout: got %0d sectors expected 9", obs_lba.size()); end
    sd.sd_ack = 1'b1; tick(); tick();
    reset_n = 1'b0; tick();
    checks++; if (sd.sd_wr !== 1'b0) begin failures++; $display("FAIL rstmid_sd_wr: got %b expected 0", sd.sd_wr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (dirty !== 1'b0) begin failures++; $display("FAIL rstmid_dirty: got %b expected 0", dirty); end
    checks++; if (sd.sd_lba !== 32'd0) begin failures++; $display("FAIL rstmid_lba: got %0d expected 0", sd.sd_lba); end
    reset_n = 1'b1; tick(); sd.sd_ack = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      tick();
      if (sd.sd_wr !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL rstmid_no_rewrite: got activity=1 expected 0"); end
    $display("test_reset_mid done");
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) tram_mem[i] = 8'($urandom);
    reset_n         = 1'b0;
    track           = '0;
    trk_we          = 1'b0;
    flush           = 1'b0;
    img_mounted     = 1'b0;
    img_size        = 64'd0;
    sd.sd_ack       = 1'b0;
    sd.sd_buff_addr = '0;
    test_reset();
    test_flush_writeback();
    test_track_change();
    test_img_mount_abort();
    test_rewrite_during_xfer();
    test_buffer_read();
    test_no_image();
    test_flush_not_dirty();
    test_we_at_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
